sb_config_loader: RTL and testbench

SB_CONFIG_LOADER -- requirements
Module: sb_config_loader

---
 rtl/sb_cfg_pkg.sv | 30 +++
 rtl/sb_config_loader_if.sv | 18 +
 rtl/sb_cfg_crc16.sv | 35 +++
 rtl/sb_config_loader.sv | 196 +++++++++++++++++++
 tb/tb_sb_config_loader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sb_cfg_pkg.sv
// ---------------------------------------------------------------------------
// sb_cfg_pkg
// Shared definitions for the switchbox configuration loader:
//   - cfg_state_e   : loader FSM states
//   - CRC16_POLY/INIT : readback CRC-16 constants (MSB-first)
//   - SETTLE_CYCLES : idle cycles between the last chain shift and DONE
//   - crc16_step()  : one serial CRC-16 update
// ---------------------------------------------------------------------------
package sb_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } cfg_state_e;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
  localparam int unsigned SETTLE_CYCLES = 2;

  // Serial CRC-16 update, one data bit, MSB-first (feedback from bit 15).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sb_config_loader_if.sv
// ---------------------------------------------------------------------------
// sb_config_loader_if
// Bitstream word handshake between a word source and the config loader.
//   word_data  : bitstream word, MSB shifted into the chain first
//   word_valid : word_data is valid (source -> loader)
//   word_ready : loader accepts word_data this cycle (loader -> source)
// Modports: master = word source, slave = loader.
// ---------------------------------------------------------------------------
interface sb_config_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/sb_cfg_crc16.sv
// ---------------------------------------------------------------------------
// sb_cfg_crc16
// Serial CRC-16 accumulator (poly 0x1021, init 0xFFFF, MSB first).
// Ports:
//   clk, nrst : clock, asynchronous active-low reset (crc -> init)
//   clear     : reload init value (has priority over en)
//   en        : fold din into the CRC this cycle
//   din       : serial data bit
//   crc       : registered CRC value, holds while en and clear are low
// ---------------------------------------------------------------------------
module sb_cfg_crc16
  import sb_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // CRC register: clear, accumulate, or hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/sb_config_loader.sv
// ---------------------------------------------------------------------------
// sb_config_loader
// Streams CHAIN_BITS of configuration, fetched as WORD_W-bit words (MSB
// first), into a serial switchbox configuration chain while holding the
// fabric isolated; releases isolation only after a complete load.
// Parameters: CHAIN_BITS (chain length), WORD_W (word width, divides CHAIN_BITS)
// Ports:
//   clk, nrst     : clock, asynchronous active-low reset
//   start, abort  : begin a load (IDLE only) / terminate a load
//   bus (slave)   : word_data / word_valid / word_ready handshake
//   cfg_bit       : serial data to the chain head (0 when not shifting)
//   cfg_shift     : chain shift enable
//   cfg_mode      : fabric isolate, 1 = routed outputs tri-stated
//   cfg_tail      : serial data from the chain tail
//   busy, done    : not IDLE / one-cycle successful completion pulse
//   error         : sticky abort flag, cleared by the next accepted start
//   readback_crc  : CRC-16 of cfg_tail over shifting cycles
// Optional feature: define SB_CFG_READBACK_EN to build the readback CRC;
// otherwise readback_crc is tied to zero.
// All outputs are registered: each is computed from the next state.
// ---------------------------------------------------------------------------
module sb_config_loader
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_BITS = 256,
  parameter int unsigned WORD_W     = 32
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                start,
  input  logic                abort,
  sb_config_loader_if.slave   bus,
  output logic                cfg_bit,
  output logic                cfg_shift,
  output logic                cfg_mode,
  input  logic                cfg_tail,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         readback_crc
);

  localparam int unsigned NUM_WORDS = CHAIN_BITS / WORD_W;
  localparam int unsigned WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int unsigned BCNT_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  if ((WORD_W < 2) || (CHAIN_BITS == 0) || ((CHAIN_BITS % WORD_W) != 0)) begin : g_param_check
    $error("sb_config_loader: CHAIN_BITS must be a non-zero multiple of WORD_W (WORD_W >= 2)");
  end

  cfg_state_e        state_r, state_s;
  logic [WORD_W-1:0] sreg_r, sreg_s;
  // bit_cnt counts bits within a word in SHIFT and is reused as the SETTLE timer.
  logic [BCNT_W-1:0] bit_cnt_r, bit_cnt_s;
  logic [WCNT_W-1:0] word_cnt_r, word_cnt_s;
  logic              word_ready_r, word_ready_s;
  logic              cfg_bit_r, cfg_bit_s;
  logic              cfg_shift_r, cfg_shift_s;
  logic              cfg_mode_r, cfg_mode_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic              start_ok_s;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s    = state_r;
    sreg_s     = sreg_r;
    bit_cnt_s  = bit_cnt_r;
    word_cnt_s = word_cnt_r;
    cfg_mode_s = cfg_mode_r;
    error_s    = error_r;
    start_ok_s = 1'b0;

    if (abort && (state_r != ST_IDLE)) begin
      // Chain is left partial, so keep the fabric isolated.
      state_s    = ST_IDLE;
      error_s    = 1'b1;
      cfg_mode_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            state_s    = ST_FETCH;
            start_ok_s = 1'b1;
            bit_cnt_s  = '0;
            word_cnt_s = '0;
            error_s    = 1'b0;
            cfg_mode_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (bus.word_valid && word_ready_r) begin
            sreg_s    = bus.word_data;
            bit_cnt_s = '0;
            state_s   = ST_SHIFT;
          end else begin
            state_s = ST_FETCH;
          end
        end
        ST_SHIFT: begin
          sreg_s = sreg_r << 1;
          if (bit_cnt_r == BCNT_W'(WORD_W - 1)) begin
            bit_cnt_s  = '0;
            word_cnt_s = word_cnt_r + WCNT_W'(1);
            if (word_cnt_r == WCNT_W'(NUM_WORDS - 1)) begin
              state_s = ST_SETTLE;
            end else begin
              state_s = ST_FETCH;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + BCNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (bit_cnt_r == BCNT_W'(SETTLE_CYCLES - 1)) begin
            bit_cnt_s  = '0;
            state_s    = ST_DONE;
            cfg_mode_s = 1'b0;
          end else begin
            bit_cnt_s = bit_cnt_r + BCNT_W'(1);
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    word_ready_s = (state_s == ST_FETCH);
    cfg_shift_s  = (state_s == ST_SHIFT);
    cfg_bit_s    = cfg_shift_s & sreg_s[WORD_W-1];
    busy_s       = (state_s != ST_IDLE);
    done_s       = (state_s == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r      <= ST_IDLE;
      sreg_r       <= '0;
      bit_cnt_r    <= '0;
      word_cnt_r   <= '0;
      word_ready_r <= 1'b0;
      cfg_bit_r    <= 1'b0;
      cfg_shift_r  <= 1'b0;
      cfg_mode_r   <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      sreg_r       <= sreg_s;
      bit_cnt_r    <= bit_cnt_s;
      word_cnt_r   <= word_cnt_s;
      word_ready_r <= word_ready_s;
      cfg_bit_r    <= cfg_bit_s;
      cfg_shift_r  <= cfg_shift_s;
      cfg_mode_r   <= cfg_mode_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  assign bus.word_ready = word_ready_r;
  assign cfg_bit        = cfg_bit_r;
  assign cfg_shift      = cfg_shift_r;
  assign cfg_mode       = cfg_mode_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;

`ifdef SB_CFG_READBACK_EN
  // The tail is sampled on exactly the cycles the chain shifts; the CRC then
  // holds until the next accepted start clears it.
  sb_cfg_crc16 u_crc16 (
    .clk   (clk),
    .nrst  (nrst),
    .clear (start_ok_s),
    .en    (cfg_shift_r),
    .din   (cfg_tail),
    .crc   (readback_crc)
  );
`else
  logic unused_readback_s;
  assign unused_readback_s = cfg_tail ^ start_ok_s;
  assign readback_crc      = 16'h0000;
`endif

endmodule

// File: tb/tb_sb_config_loader.sv
// ---------------------------------------------------------------------------
// tb_sb_config_loader
// Directed bench for sb_config_loader (CHAIN_BITS=256, WORD_W=32).
// The driver pushes the expected serial bits of every word it presents into
// exp_q; a monitor pops one per cfg_shift cycle and compares cfg_bit. A
// 256-bit chain model (pre-loaded with ones) feeds cfg_tail.
// ---------------------------------------------------------------------------
module tb_sb_config_loader;

  logic clk = 1'b0;
  logic nrst, start, abort, cfg_bit, cfg_shift, cfg_mode, cfg_tail, busy, done, error;
  logic [15:0] readback_crc;

  sb_config_loader_if #(.WORD_W(32)) bus ();

  sb_config_loader #(.CHAIN_BITS(256), .WORD_W(32)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start        (start),
    .abort        (abort),
    .bus          (bus),
    .cfg_bit      (cfg_bit),
    .cfg_shift    (cfg_shift),
    .cfg_mode     (cfg_mode),
    .cfg_tail     (cfg_tail),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .readback_crc (readback_crc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int shift_cnt = 0, shift_base = 0, last_shift_cyc = 0;
  int done_cnt = 0, done_base = 0, done_cyc = 0;
  logic [7:0]   bits8;
  logic [255:0] chain;
  logic [255:0] snap;
  logic [255:0] chain_b;
  logic [31:0]  words [8];
  logic         exp_q [$];

  initial chain = {256{1'b1}};
  assign cfg_tail = chain[255];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

`ifdef SB_CFG_READBACK_EN
  function automatic logic [15:0] crc_ref(input logic [255:0] bits);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 255; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = (c << 1) ^ 16'h1021;
      else c = c << 1;
    end
    return c;
  endfunction
`endif

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cfg_shift) chain <= {chain[254:0], cfg_bit};
  end

  // Monitor: scoreboard pop on every shifting cycle.
  always @(negedge clk) begin
    if (nrst) begin
      if (cfg_shift) begin
        shift_cnt = shift_cnt + 1;
        last_shift_cyc = cyc;
        if (shift_cnt - shift_base <= 8) bits8 = {bits8[6:0], cfg_bit};
        if (exp_q.size() == 0) fail_now("cfg_bit_unexpected");
        else check("cfg_bit", cfg_bit, exp_q.pop_front());
      end else begin
        check("cfg_bit_zero_when_idle", cfg_bit, 0);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.word_ready) fail_now(name);
  endtask

  // Start a load and present all words; optional gap before word gap_before,
  // optional abort a few cycles into word abort_word.
  task automatic do_load(input int gap_before, input int abort_word);
    snap = chain;
    shift_base = shift_cnt;
    done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("error_clear_on_start", error, 0);
    check("cfg_mode_fetch", cfg_mode, 1);
    check("busy_fetch", busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_before) begin
        wait_ready("gap_ready_timeout");
        repeat (10) begin
          check("gap_word_ready", bus.word_ready, 1);
          check("gap_cfg_shift", cfg_shift, 0);
          @(negedge clk);
        end
      end
      bus.word_data = words[i];
      bus.word_valid = 1'b1;
      for (int b = 31; b >= 0; b--) exp_q.push_back(words[i][b]);
      wait_ready("word_ready_timeout");
      @(negedge clk);
      bus.word_valid = 1'b0;
      if (i == abort_word) begin
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_error", error, 1);
        check("abort_cfg_mode", cfg_mode, 1);
        check("abort_cfg_shift", cfg_shift, 0);
        check("abort_word_ready", bus.word_ready, 0);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic finish_load();
    int n;
    logic [255:0] exp_chain;
    exp_chain = '0;
    for (int i = 0; i < 8; i++) exp_chain = (exp_chain << 32) | {224'd0, words[i]};
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("done_timeout");
    check("done_cfg_mode", cfg_mode, 0);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("done_pulses", done_cnt - done_base, 1);
    check("done_latency", done_cyc - last_shift_cyc, 3);
    check("shift_total", shift_cnt - shift_base, 256);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_cfg_mode", cfg_mode, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    check("chain_contents", chain, exp_chain);
`ifdef SB_CFG_READBACK_EN
    check("readback_crc", readback_crc, crc_ref(snap));
    repeat (3) @(negedge clk);
    check("readback_crc_hold", readback_crc, crc_ref(snap));
`else
    check("readback_crc_zero", readback_crc, 0);
`endif
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_word_ready", bus.word_ready, 0);
    check("rst_cfg_bit", cfg_bit, 0);
    check("rst_cfg_shift", cfg_shift, 0);
    check("rst_cfg_mode", cfg_mode, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Load A: single marker byte, chain pre-loaded with ones.
    words = '{32'hA5000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    do_load(-1, -1);
    finish_load();
    check("first_8_bits", bits8, 8'b10100101);
    check("chain_top_byte", chain[255:248], 8'hA5);

    // Load B: mixed patterns, no gap.
    words = '{32'hA5000000, 32'h12345678, 32'hDEADBEEF, 32'h0F0F0F0F,
              32'h80000001, 32'hFFFFFFFF, 32'h00000000, 32'hCAFEF00D};
    do_load(-1, -1);
    finish_load();
    chain_b = chain;

    // Load C: same words, 10-cycle valid gap between words 3 and 4.
    do_load(4, -1);
    finish_load();
    check("gap_chain_vs_nogap", chain, chain_b);

    // Abort during word 5: no done afterwards.
    do_load(-1, 5);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - done_base, 0);
    check("abort_idle_cfg_mode", cfg_mode, 1);

    // start together with abort in IDLE is treated as abort.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_error_kept", error, 1);

    // Recovery load: start clears error (checked inside do_load).
    do_load(-1, -1);
    finish_load();
    check("recover_error", error, 0);

    // Reset asserted in SETTLE.
    do_load(-1, -1);
    begin
      int n;
      n = 0;
      while (cfg_shift || bus.word_ready || !busy) begin
        if (n >= 100) break;
        @(negedge clk);
        n++;
      end
      if (cfg_shift || bus.word_ready || !busy) fail_now("settle_timeout");
    end
    nrst = 1'b0;
    #1;
    check("settle_rst_word_ready", bus.word_ready, 0);
    check("settle_rst_cfg_bit", cfg_bit, 0);
    check("settle_rst_cfg_shift", cfg_shift, 0);
    check("settle_rst_cfg_mode", cfg_mode, 1);
    check("settle_rst_busy", busy, 0);
    check("settle_rst_done", done, 0);
    check("settle_rst_error", error, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (6) @(negedge clk);
    check("settle_rst_no_done", done_cnt - done_base, 0);
    check("settle_rst_cfg_mode_hold", cfg_mode, 1);
    check("settle_rst_scoreboard", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
